sm4_key_schedule: RTL

- Expands a 128-bit SM4 master key into 32 round keys rk0..rk31, one per cycle, and stores them.
- Streams the stored round keys to the round datapath:
  - ascending order (rk0 first) for encryption;
  - descending order (rk31 first) for decryption.
- Supplies the decryption-direction key ordering for the SM4 core.
- Uses four instances of the team byte S-box module sbox_memory for the tau step.

---
 rtl/sbox_memory.sv | 32 +++
 rtl/sm4_key_schedule.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sbox_memory.sv
// SM4 byte substitution box: combinational 256-entry lookup.
module sbox_memory (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [2047:0] SboxC = {
        128'hd690e9fe_cce13db7_16b614c2_28fb2c05,
        128'h2b679a76_2abe04c3_aa441326_49860699,
        128'h9c4250f4_91ef987a_33540b43_edcfac62,
        128'he4b31ca9_c908e895_80df94fa_758f3fa6,
        128'h4707a7fc_f37317ba_83593c19_e6854fa8,
        128'h686b81b2_7164da8b_f8eb0f4b_70569d35,
        128'h1e240e5e_6358d1a2_25227c3b_01217887,
        128'hd4004657_9fd32752_4c3602e7_a0c4c89e,
        128'heabf8ad2_40c738b5_a3f7f2ce_f96115a1,
        128'he0ae5da4_9b341a55_ad933230_f58cb1e3,
        128'h1df6e22e_8266ca60_c02923ab_0d534e6f,
        128'hd5db3745_defd8e2f_03ff6a72_6d6c5b51,
        128'h8d1baf92_bbddbc7f_11d95c41_1f105ad8,
        128'h0ac13188_a5cd7bbd_2d74d012_b8e5b4b0,
        128'h8969974a_0c96777e_65b9f109_c56ec684,
        128'h18f07dec_3adc4d20_79ee5f3e_d7cb3948
    };

    logic [10:0] w_off;

    // Entry k sits at bit offset (255-k)*8, and 255-k is simply ~k for a byte.
    assign w_off  = {~data_i, 3'b000};
    assign data_o = SboxC[w_off +: 8];

endmodule

// File: rtl/sm4_key_schedule.sv
// SM4 key expansion: builds rk0..rk31 one per cycle, then streams them enc- or dec-ordered.
// Optional macro SM4_KS_ZEROIZE_EN adds zeroize_i to wipe stored keys and the K window.
module sm4_key_schedule #(
    parameter int unsigned rounds_p = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         key_v_i,
    input  logic [127:0] key_i,
    output logic         key_ready_o,
    output logic         keys_valid_o,
    input  logic         stream_start_i,
    input  logic         stream_dec_i,
    output logic         rk_v_o,
    output logic [31:0]  rk_o,
    output logic [4:0]   rk_idx_o,
    input  logic         rk_yumi_i
`ifdef SM4_KS_ZEROIZE_EN
    ,
    input  logic         zeroize_i
`endif
);

    if (rounds_p != 32) begin : g_bad_rounds
        $error("sm4_key_schedule: rounds_p must be 32");
    end

    localparam logic [127:0] FkC = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    typedef enum logic [1:0] {StIdle, StExpand, StReady, StStream} state_e;

    state_e      r_state, w_state_next;
    logic [31:0] r_win [4];
    logic [31:0] r_rk  [32];
    logic [4:0]  r_cnt, r_ptr, r_idx;
    logic        r_dec;
    logic        w_zero, w_load, w_start, w_take;
    logic [31:0] w_ck, w_tau_in, w_tau_out, w_lin, w_new;

`ifdef SM4_KS_ZEROIZE_EN
    assign w_zero = zeroize_i;
`else
    assign w_zero = 1'b0;
`endif

    // CK bytes are (4i+j)*7 with a natural 8-bit wrap.
    for (genvar g = 0; g < 4; g++) begin : g_tau
        assign w_ck[31-8*g -: 8] = {1'b0, r_cnt, 2'(g)} * 8'd7;
        sbox_memory u_sbox (
            .data_i(w_tau_in[31-8*g -: 8]),
            .data_o(w_tau_out[31-8*g -: 8])
        );
    end

    assign w_tau_in = r_win[1] ^ r_win[2] ^ r_win[3] ^ w_ck;
    assign w_lin    = w_tau_out ^ {w_tau_out[18:0], w_tau_out[31:19]}
                                ^ {w_tau_out[8:0], w_tau_out[31:9]};
    assign w_new    = r_win[0] ^ w_lin;

    always_comb begin
        w_state_next = r_state;
        key_ready_o  = 1'b0;
        keys_valid_o = 1'b0;
        rk_v_o       = 1'b0;
        w_load       = 1'b0;
        w_start      = 1'b0;
        w_take       = 1'b0;
        case (r_state)
            StIdle: begin
                key_ready_o = 1'b1;
                if (key_v_i) begin
                    w_load       = 1'b1;
                    w_state_next = StExpand;
                end
            end
            StExpand: begin
                if (r_cnt == 5'd31) w_state_next = StReady;
            end
            StReady: begin
                key_ready_o  = 1'b1;
                keys_valid_o = 1'b1;
                // A new key beats a simultaneous stream request.
                if (key_v_i) begin
                    w_load       = 1'b1;
                    w_state_next = StExpand;
                end else if (stream_start_i) begin
                    w_start      = 1'b1;
                    w_state_next = StStream;
                end
            end
            StStream: begin
                rk_v_o       = 1'b1;
                keys_valid_o = 1'b1;
                if (rk_yumi_i) begin
                    w_take = 1'b1;
                    if (r_idx == 5'd31) w_state_next = StReady;
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (w_zero) begin
            w_state_next = StIdle;
            w_load       = 1'b0;
            w_start      = 1'b0;
            w_take       = 1'b0;
        end
    end

    assign rk_o     = rk_v_o ? r_rk[r_ptr] : 32'h0;
    assign rk_idx_o = r_idx;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= StIdle;
            r_cnt   <= 5'd0;
            r_ptr   <= 5'd0;
            r_idx   <= 5'd0;
            r_dec   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_cnt <= 5'd0;
            end else if (r_state == StExpand) begin
                r_cnt <= r_cnt + 5'd1;
            end
            if (w_start) begin
                r_dec <= stream_dec_i;
                r_ptr <= stream_dec_i ? 5'd31 : 5'd0;
                r_idx <= 5'd0;
            end else if (w_take) begin
                r_ptr <= r_dec ? r_ptr - 5'd1 : r_ptr + 5'd1;
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    // Key material is deliberately left out of reset; keys_valid_o guards it.
    always_ff @(posedge clk_i) begin
        if (w_zero) begin
            for (int i = 0; i < 4; i++) r_win[i] <= 32'h0;
            for (int i = 0; i < 32; i++) r_rk[i] <= 32'h0;
        end else if (!reset_i) begin
            if (w_load) begin
                for (int i = 0; i < 4; i++) begin
                    r_win[i] <= key_i[127-32*i -: 32] ^ FkC[127-32*i -: 32];
                end
            end else if (r_state == StExpand) begin
                r_rk[r_cnt] <= w_new;
                r_win[0]    <= r_win[1];
                r_win[1]    <= r_win[2];
                r_win[2]    <= r_win[3];
                r_win[3]    <= w_new;
            end
        end
    end

endmodule
